mul_seq: RTL and testbench

- Iterative shift-add multiply sequencer for the EX stage.
- Executes mul, mulh and mulhu, aluop 4'b0101 / 4'b0110 / 4'b0111, over multiple cycles.
- Holds the pipeline through its stall output until the result is ready.
- Replaces a single-cycle 32x32 multiplier in the ALU; the EX-stage mux selects its result on done.

---
 rtl/mul_seq_if.sv | 24 ++
 rtl/mul_seq.sv | 117 +++++++++++
 tb/tb_mul_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// mul_seq_if: EX-stage <-> multiply sequencer request/response bundle.
// Ports: start/aluop/a/b run from the EX stage to the sequencer; stall/done/result run back.
// master = EX stage (drives the request), slave = mul_seq (drives the response).
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, aluop, a, b,
    input  stall, done, result
  );

  modport slave (
    input  start, aluop, a, b,
    output stall, done, result
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier for mul / mulh / mulhu (aluop 0101/0110/0111).
// Latency: load at the start edge, WIDTH RUN cycles, done one cycle later (MUL_EARLY_OUT_EN: RUN ends once the multiplier runs out of ones).
// Backpressure: stall is held high from the accepted start through the last RUN cycle; the EX stage freezes on it.
// Ports: clk, rst (sync, active-high), bus (mul_seq_if.slave: start, aluop, a, b -> stall, done, result).
// Optional macro: MUL_EARLY_OUT_EN.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  mul_seq_if.slave  bus
);

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 hi_sel;
  logic [WIDTH-1:0]     result_q;

  logic                 valid_op;
  logic                 is_mulh;
  logic                 load;
  logic                 last;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   prod;

  assign valid_op = (bus.aluop == OP_MUL) || (bus.aluop == OP_MULH) || (bus.aluop == OP_MULHU);
  assign is_mulh  = (bus.aluop == OP_MULH);
  // A new op is accepted whenever the sequencer is not mid-run, including back-to-back from DONE.
  assign load     = (state_q != RUN) && bus.start && valid_op;

  // Signed magnitude for mulh; the most-negative value maps to 2^(WIDTH-1), which is exact as unsigned.
  assign a_mag = (is_mulh && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (is_mulh && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The final iteration's add is folded in here so the registered result includes it.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign prod    = neg ? -acc_nxt : acc_nxt;

`ifdef MUL_EARLY_OUT_EN
  // Stop once the remaining multiplier bits after this shift are all zero.
  assign last = (cnt == CNT_W'(WIDTH-1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = (cnt == CNT_W'(WIDTH-1));
`endif

  always_comb begin
    state_d   = state_q;
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = RUN;
          bus.stall = 1'b1;
        end
      end
      RUN: begin
        bus.stall = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (load) begin
          state_d   = RUN;
          bus.stall = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      hi_sel   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        cnt    <= '0;
        neg    <= is_mulh && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        hi_sel <= (bus.aluop != OP_MUL);
      end else if (state_q == RUN) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (last) result_q <= hi_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      end
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and random multiply ops against an arithmetic reference model.
// Latency: expected done cycle derived from the operation and the multiplier magnitude.
// Backpressure: stall must cover every cycle from the accepted start to the last RUN cycle.
module tb_mul_seq;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mul_seq_if #(.WIDTH(WIDTH)) bus ();

  mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        pu;
    logic signed [63:0] ps;
    pu = {32'b0, x} * {32'b0, y};
    ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    case (op)
      OP_MUL:  return pu[31:0];
      OP_MULH: return ps[63:32];
      default: return pu[63:32];
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
`ifdef MUL_EARLY_OUT_EN
    logic [31:0] mag;
    int k;
    mag = (op == OP_MULH && y[31]) ? -y : y;
    k = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
    return 1 + k;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request in the current (post-negedge) cycle, check combinational stall, then cross the load edge.
  task automatic launch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic exp_stall, input string tag);
    bus.start = 1'b1;
    bus.aluop = op;
    bus.a     = x;
    bus.b     = y;
    #1;
    check({tag, "_stall_at_start"}, {31'b0, bus.stall}, {31'b0, exp_stall});
    @(posedge clk);
  endtask

  // Returns at the negedge of the done cycle; scrambles a/b after the load edge.
  task automatic wait_done(input logic [31:0] exp_res, input int exp_lat, input string tag);
    int n;
    int stall_low;
    n = 0;
    stall_low = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) break;
      if (bus.stall !== 1'b1) stall_low++;
      if (n > WIDTH + 8) break;
      bus.start = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_stall_gaps"}, stall_low, 0);
    check({tag, "_stall_in_done"}, {31'b0, bus.stall}, 32'd0);
  endtask

  task automatic op_run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input string tag);
    @(negedge clk);
    launch(op, x, y, 1'b1, tag);
    wait_done(exp_res, ref_lat(op, y), tag);
  endtask

  initial begin
    int bad;
    logic [3:0]  op;
    logic [31:0] x, y;

    bus.start = 1'b0;
    bus.aluop = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall",  {31'b0, bus.stall}, 32'd0);
    check("reset_done",   {31'b0, bus.done},  32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;

    op_run(OP_MUL,   32'd7,        32'd6,        32'h0000002A, "mul_7x6");
    op_run(OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1xm1");
    op_run(OP_MULH,  32'h80000000, 32'd2,        32'hFFFFFFFF, "mulh_minx2");
    op_run(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ffxff");
    op_run(OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, "mulh_minxmin");
    op_run(OP_MUL,   32'h12345678, 32'd0,        32'h00000000, "mul_zero");

    // Back-to-back: second start lands in the DONE cycle of the first.
    op_run(OP_MUL, 32'd3, 32'd5, 32'h0000000F, "b2b_first");
    launch(OP_MULHU, 32'h80000000, 32'd4, 1'b1, "b2b_second");
    wait_done(32'h00000002, ref_lat(OP_MULHU, 32'd4), "b2b_second");

    op_run(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ffxff");

    // Non-multiply op must be ignored entirely.
    @(negedge clk);
    launch(4'b0011, 32'd9, 32'd9, 1'b0, "invalid_op");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.stall !== 1'b0) bad++;
      bus.start = 1'b0;
    end
    check("invalid_op_quiet", bad, 0);
    check("invalid_op_result_held", bus.result, 32'hFFFFFFFE);

    // Reset in RUN cycle 10 discards the op and clears the result.
    @(negedge clk);
    launch(OP_MUL, 32'h00001234, 32'h00005678, 1'b1, "rst_mid");
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_stall",  {31'b0, bus.stall}, 32'd0);
    check("rst_mid_done",   {31'b0, bus.done},  32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    op_run(OP_MUL, 32'd2, 32'd2, 32'd4, "after_rst");

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: op = OP_MUL;
        1: op = OP_MULH;
        default: op = OP_MULHU;
      endcase
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = y & 32'h000000FF;
        1: x = 32'h80000000;
        2: y = (i % 2 == 0) ? 32'h80000000 : 32'd0;
        default: ;
      endcase
      op_run(op, x, y, ref_mul(op, x, y), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
